// File: rtl/filter_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : filter_reduce_pkg
// Brief   : Shared types, latency constant and saturating add helper for the
//           filter/reduce/accumulate stage.
// Revision: 1.0
// ============================================================================
package filter_reduce_pkg;

    typedef enum logic [1:0] {
        OP_PASS   = 2'd0,
        OP_REDUCE = 2'd1,
        OP_ACCUM  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic {
        AXIS_BINS  = 1'b0,
        AXIS_ELEMS = 1'b1
    } axis_e;

    typedef enum logic [1:0] {
        CFG_OP       = 2'd0,
        CFG_THR_ADDR = 2'd1,
        CFG_AXIS     = 2'd2
    } cfg_sel_e;

    localparam int LATENCY = 2;

    // Operands are zero-extended by the caller; result clamps at 2^width-1.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << width) - 33'd1;
        return (sum > max_v) ? max_v[31:0] : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fru_bin_compare.sv
`default_nettype none
// ============================================================================
// Module  : fru_bin_compare
// Brief   : Combinational N x M bin-hit matrix; hit[i*M+j] = element i in bin j.
// Revision: 1.0
// ============================================================================
module fru_bin_compare #(
    parameter int N          = 8,
    parameter int M          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic [N*DATA_WIDTH-1:0] vector,
    input  logic [M*DATA_WIDTH-1:0] thr,
    output logic [N*M-1:0]          hit
);

    for (genvar i = 0; i < N; i++) begin : g_elem
        logic signed [DATA_WIDTH-1:0] w_x;
        assign w_x = $signed(vector[i*DATA_WIDTH +: DATA_WIDTH]);

        for (genvar j = 0; j < M; j++) begin : g_bin
            logic signed [DATA_WIDTH-1:0] w_lo;
            assign w_lo = $signed(thr[j*DATA_WIDTH +: DATA_WIDTH]);

            if (j < M - 1) begin : g_mid
                logic signed [DATA_WIDTH-1:0] w_hi;
                assign w_hi = $signed(thr[(j+1)*DATA_WIDTH +: DATA_WIDTH]);
                assign hit[i*M+j] = (w_lo < w_x) && (w_x <= w_hi);
            end else begin : g_top
                assign hit[i*M+j] = (w_x > w_lo);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_reduce_accum_unit.sv
`default_nettype none
// ============================================================================
// Module  : filter_reduce_accum_unit
// Brief   : Classifies lanes against per-chain bin thresholds, reduces the hit
//           matrix along a selectable axis and optionally accumulates per chain.
// Revision: 1.0
// ============================================================================
module filter_reduce_accum_unit
    import filter_reduce_pkg::*;
#(
    parameter int N          = 8,
    parameter int M          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter int FUVRF_SIZE = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    input  logic                          cfg_en,
    input  logic [$clog2(MAX_CHAINS)-1:0] cfg_chain,
    input  logic [1:0]                    cfg_sel,
    input  logic [7:0]                    cfg_data,
    input  logic                          thr_wr_en,
    input  logic [$clog2(FUVRF_SIZE)-1:0] thr_wr_set,
    input  logic [$clog2(M)-1:0]          thr_wr_bin,
    input  logic [DATA_WIDTH-1:0]         thr_wr_data,
    input  logic                          acc_clear,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
    output logic                          valid_out,
    output logic                          eof_out
);

    localparam int CH_W  = $clog2(MAX_CHAINS);
    localparam int SET_W = $clog2(FUVRF_SIZE);
    localparam int CNT_W = $clog2(N + 1);

    op_e                    r_cfg_op       [MAX_CHAINS];
    logic [SET_W-1:0]       r_cfg_thr_addr [MAX_CHAINS];
    axis_e                  r_cfg_axis     [MAX_CHAINS];
    logic [M*DATA_WIDTH-1:0] r_thr         [FUVRF_SIZE];
    logic [ACC_WIDTH-1:0]   r_acc          [MAX_CHAINS][N];

    logic                    r_s1_valid;
    logic                    r_s1_eof;
    logic [CH_W-1:0]         r_s1_chain;
    logic [N*DATA_WIDTH-1:0] r_s1_vec;
    op_e                     r_s1_op;
    axis_e                   r_s1_axis;
    logic [M*DATA_WIDTH-1:0] r_s1_thr;

    logic [N*DATA_WIDTH-1:0] r_out_vec;
    logic [CH_W-1:0]         r_out_chain;
    logic                    r_out_valid;
    logic                    r_out_eof;

    logic [N*M-1:0]          w_hit;
    logic [CNT_W-1:0]        w_red     [N];
    logic [ACC_WIDTH-1:0]    w_acc_new [N];
    logic [N*DATA_WIDTH-1:0] w_out_vec;
    logic                    w_emit;
    logic                    w_unused_cfg_bits;

    assign w_unused_cfg_bits = ^cfg_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                r_cfg_op[c]       <= OP_PASS;
                r_cfg_thr_addr[c] <= '0;
                r_cfg_axis[c]     <= AXIS_BINS;
            end
        end else if (cfg_en) begin
            case (cfg_sel_e'(cfg_sel))
                CFG_OP:       r_cfg_op[cfg_chain]       <= op_e'(cfg_data[1:0]);
                CFG_THR_ADDR: r_cfg_thr_addr[cfg_chain] <= cfg_data[SET_W-1:0];
                CFG_AXIS:     r_cfg_axis[cfg_chain]     <= axis_e'(cfg_data[0]);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < FUVRF_SIZE; s++) r_thr[s] <= '0;
        end else if (thr_wr_en) begin
            r_thr[thr_wr_set][thr_wr_bin*DATA_WIDTH +: DATA_WIDTH] <= thr_wr_data;
        end
    end

    // S1: beat, its chain config and its threshold set are all captured together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_chain <= '0;
            r_s1_vec   <= '0;
            r_s1_op    <= OP_PASS;
            r_s1_axis  <= AXIS_BINS;
            r_s1_thr   <= '0;
        end else begin
            r_s1_valid <= valid_in && tracing;
            if (valid_in && tracing) begin
                r_s1_eof   <= eof_in;
                r_s1_chain <= chainId_in;
                r_s1_vec   <= vector_in;
                r_s1_op    <= r_cfg_op[chainId_in];
                r_s1_axis  <= r_cfg_axis[chainId_in];
                r_s1_thr   <= r_thr[r_cfg_thr_addr[chainId_in]];
            end
        end
    end

    fru_bin_compare #(
        .N          (N),
        .M          (M),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bin_compare (
        .vector (r_s1_vec),
        .thr    (r_s1_thr),
        .hit    (w_hit)
    );

    always_comb begin
        for (int i = 0; i < N; i++) w_red[i] = '0;
        if (r_s1_axis == AXIS_BINS) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < M; j++)
                    w_red[i] = w_red[i] + CNT_W'(w_hit[i*M+j]);
        end else begin
            for (int j = 0; j < M; j++)
                for (int i = 0; i < N; i++)
                    w_red[j] = w_red[j] + CNT_W'(w_hit[i*M+j]);
        end
    end

    // A concurrent clear zeroes the base before this beat is added.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_acc_new[i] = ACC_WIDTH'(sat_add(acc_clear ? 32'd0 : 32'(r_acc[r_s1_chain][i]),
                                              32'(w_red[i]), ACC_WIDTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < MAX_CHAINS; c++)
                for (int i = 0; i < N; i++) r_acc[c][i] <= '0;
        end else begin
            if (acc_clear) begin
                for (int c = 0; c < MAX_CHAINS; c++)
                    for (int i = 0; i < N; i++) r_acc[c][i] <= '0;
            end
            if (r_s1_valid && r_s1_op == OP_ACCUM) begin
                for (int i = 0; i < N; i++)
                    r_acc[r_s1_chain][i] <= r_s1_eof ? '0 : w_acc_new[i];
            end
        end
    end

    assign w_emit = r_s1_valid && ((r_s1_op != OP_ACCUM) || r_s1_eof);

    always_comb begin
        w_out_vec = r_s1_vec;
        for (int i = 0; i < N; i++) begin
            case (r_s1_op)
                OP_REDUCE: w_out_vec[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_red[i]);
                OP_ACCUM:  w_out_vec[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_acc_new[i]);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vec   <= '0;
            r_out_chain <= '0;
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_eof   <= w_emit && r_s1_eof;
            if (w_emit) begin
                r_out_vec   <= w_out_vec;
                r_out_chain <= r_s1_chain;
            end
        end
    end

    assign vector_out  = r_out_vec;
    assign chainId_out = r_out_chain;
    assign valid_out   = r_out_valid;
    assign eof_out     = r_out_eof;

endmodule
`default_nettype wire

// File: tb/tb_filter_reduce_accum_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_filter_reduce_accum_unit
// Brief   : Directed scoreboard bench for filter_reduce_accum_unit (N=M=4).
// Revision: 1.0
// ============================================================================
module tb_filter_reduce_accum_unit;
    import filter_reduce_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tracing = 1'b0;
    logic         valid_in = 1'b0;
    logic         eof_in = 1'b0;
    logic [1:0]   chainId_in = '0;
    logic [127:0] vector_in = '0;
    logic         cfg_en = 1'b0;
    logic [1:0]   cfg_chain = '0;
    logic [1:0]   cfg_sel = '0;
    logic [7:0]   cfg_data = '0;
    logic         thr_wr_en = 1'b0;
    logic [1:0]   thr_wr_set = '0;
    logic [1:0]   thr_wr_bin = '0;
    logic [31:0]  thr_wr_data = '0;
    logic         acc_clear = 1'b0;

    logic [127:0] vector_out, sat_vector_out;
    logic [1:0]   chainId_out, sat_chainId_out;
    logic         valid_out, sat_valid_out;
    logic         eof_out, sat_eof_out;

    filter_reduce_accum_unit #(.N(4), .M(4), .DATA_WIDTH(32), .MAX_CHAINS(4),
                               .FUVRF_SIZE(4), .ACC_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .chainId_in(chainId_in), .vector_in(vector_in),
        .cfg_en(cfg_en), .cfg_chain(cfg_chain), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .thr_wr_en(thr_wr_en), .thr_wr_set(thr_wr_set), .thr_wr_bin(thr_wr_bin),
        .thr_wr_data(thr_wr_data), .acc_clear(acc_clear), .vector_out(vector_out),
        .chainId_out(chainId_out), .valid_out(valid_out), .eof_out(eof_out));

    filter_reduce_accum_unit #(.N(4), .M(4), .DATA_WIDTH(32), .MAX_CHAINS(4),
                               .FUVRF_SIZE(4), .ACC_WIDTH(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .chainId_in(chainId_in), .vector_in(vector_in),
        .cfg_en(cfg_en), .cfg_chain(cfg_chain), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .thr_wr_en(thr_wr_en), .thr_wr_set(thr_wr_set), .thr_wr_bin(thr_wr_bin),
        .thr_wr_data(thr_wr_data), .acc_clear(acc_clear), .vector_out(sat_vector_out),
        .chainId_out(sat_chainId_out), .valid_out(sat_valid_out), .eof_out(sat_eof_out));

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [127:0] vec;
        int           ch;
        bit           eof;
        int           due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    int thr_m  [4][4];
    int op_m   [4];
    int addr_m [4];
    int axis_m [4];
    int acc_m  [4][4];

    function automatic logic [127:0] vec4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] model_reduce(input logic [127:0] v, input int set, input int axis);
        logic [127:0] r;
        int cnt [4];
        int x;
        bit hit;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int i = 0; i < 4; i++) begin
            x = v[i*32 +: 32];
            for (int j = 0; j < 4; j++) begin
                if (j < 3) hit = (thr_m[set][j] < x) && (x <= thr_m[set][j+1]);
                else       hit = (x > thr_m[set][3]);
                if (hit) begin
                    if (axis == 0) cnt[i]++;
                    else           cnt[j]++;
                end
            end
        end
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = cnt[k];
        return r;
    endfunction

    function automatic void push(input logic [127:0] v, input int ch, input bit eof);
        exp_t e;
        e.vec = v; e.ch = ch; e.eof = eof; e.due = cycle + LATENCY;
        sb.push_back(e);
    endfunction

    function automatic void expect_beat(input int ch, input logic [127:0] v, input bit eof);
        logic [127:0] red, accv;
        red = model_reduce(v, addr_m[ch], axis_m[ch]);
        if (op_m[ch] == 1) begin
            push(red, ch, eof);
        end else if (op_m[ch] == 2) begin
            for (int i = 0; i < 4; i++) begin
                acc_m[ch][i] += int'(red[i*32 +: 32]);
                if (acc_m[ch][i] > 65535) acc_m[ch][i] = 65535;
            end
            if (eof) begin
                for (int i = 0; i < 4; i++) accv[i*32 +: 32] = acc_m[ch][i];
                push(accv, ch, 1'b1);
                for (int i = 0; i < 4; i++) acc_m[ch][i] = 0;
            end
        end else begin
            push(v, ch, eof);
        end
    endfunction

    function automatic void clear_strobes();
        cfg_en = 1'b0; thr_wr_en = 1'b0; acc_clear = 1'b0;
    endfunction

    function automatic void cfg_model(input int ch, input int sel, input int data);
        if (sel == 0) op_m[ch] = data;
        else if (sel == 1) addr_m[ch] = data;
        else axis_m[ch] = data;
    endfunction

    task automatic beat(input int ch, input logic [127:0] v, input bit eof, input bit tr);
        @(negedge clk);
        clear_strobes();
        tracing = tr; valid_in = 1'b1; chainId_in = 2'(ch); vector_in = v; eof_in = eof;
        if (tr) expect_beat(ch, v, eof);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_strobes();
            valid_in = 1'b0; eof_in = 1'b0;
        end
    endtask

    task automatic cfg(input int ch, input int sel, input int data);
        @(negedge clk);
        clear_strobes();
        valid_in = 1'b0;
        cfg_en = 1'b1; cfg_chain = 2'(ch); cfg_sel = 2'(sel); cfg_data = 8'(data);
        cfg_model(ch, sel, data);
    endtask

    task automatic thr(input int set, input int bin, input int data);
        @(negedge clk);
        clear_strobes();
        valid_in = 1'b0;
        thr_wr_en = 1'b1; thr_wr_set = 2'(set); thr_wr_bin = 2'(bin); thr_wr_data = data;
        thr_m[set][bin] = data;
    endtask

    task automatic check_zero_outputs();
        checks++; assert (valid_out === 1'b0) else begin errors++; $error("FAIL rst_valid got %0b exp 0", valid_out); end
        checks++; assert (eof_out === 1'b0) else begin errors++; $error("FAIL rst_eof got %0b exp 0", eof_out); end
        checks++; assert (chainId_out === 2'd0) else begin errors++; $error("FAIL rst_chain got %0d exp 0", chainId_out); end
        checks++; assert (vector_out === 128'd0) else begin errors++; $error("FAIL rst_vector got %h exp 0", vector_out); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_strobes();
        reset_n = 1'b0; valid_in = 1'b0; eof_in = 1'b0; tracing = 1'b0;
        for (int c = 0; c < 4; c++) begin
            op_m[c] = 0; addr_m[c] = 0; axis_m[c] = 0;
            for (int k = 0; k < 4; k++) begin thr_m[c][k] = 0; acc_m[c][k] = 0; end
        end
        repeat (2) @(negedge clk);
        check_zero_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        bit   exp_valid;
        exp_t e;
        exp_valid = (sb.size() > 0) && (sb[0].due == cycle);
        checks++;
        assert (valid_out === exp_valid) else begin
            errors++; $error("FAIL valid_out cycle %0d got %0b exp %0b", cycle, valid_out, exp_valid);
        end
        if (exp_valid) begin
            e = sb.pop_front();
            if (valid_out === 1'b1) begin
                checks++;
                assert (vector_out === e.vec) else begin
                    errors++; $error("FAIL vector_out cycle %0d got %h exp %h", cycle, vector_out, e.vec);
                end
                checks++;
                assert (chainId_out === 2'(e.ch)) else begin
                    errors++; $error("FAIL chainId_out cycle %0d got %0d exp %0d", cycle, chainId_out, e.ch);
                end
                checks++;
                assert (eof_out === e.eof) else begin
                    errors++; $error("FAIL eof_out cycle %0d got %0b exp %0b", cycle, eof_out, e.eof);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        logic [127:0] vneg;
        logic [127:0] v0;
        int drain;

        v    = vec4(5, 5, 25, 0);
        vneg = vec4(-60, -100, 70, 0);
        v0   = vec4(-5, 12, 35, 10);

        do_reset();

        thr(0, 0, 0);    thr(0, 1, 10);  thr(0, 2, 20); thr(0, 3, 30);
        thr(1, 0, -100); thr(1, 1, -50); thr(1, 2, 0);  thr(1, 3, 50);

        // Reduce on both axes, then pass-through.
        cfg(0, 0, 1); cfg(0, 2, 1);
        beat(0, v, 1'b0, 1'b1);
        cfg(0, 2, 0);
        beat(0, v, 1'b1, 1'b1);
        cfg(0, 0, 0);
        beat(0, v, 1'b0, 1'b1);
        idle(3);

        // Negative thresholds and exact boundaries, plus op 3 behaving as pass.
        cfg(0, 0, 1); cfg(0, 1, 1);
        beat(0, vneg, 1'b0, 1'b1);
        cfg(0, 2, 1);
        beat(0, vneg, 1'b0, 1'b1);
        cfg(0, 0, 3);
        beat(0, vneg, 1'b0, 1'b1);
        cfg(0, 0, 1); cfg(0, 1, 0);
        idle(3);

        // Config write in the capture cycle must not affect the captured beat.
        @(negedge clk);
        clear_strobes();
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = v; eof_in = 1'b0; tracing = 1'b1;
        cfg_en = 1'b1; cfg_chain = 2'd0; cfg_sel = 2'd2; cfg_data = 8'd0;
        expect_beat(0, v, 1'b0);
        cfg_model(0, 2, 0);
        beat(0, v, 1'b0, 1'b1);
        cfg(0, 2, 1);

        // Threshold write to the set being read returns the old set.
        @(negedge clk);
        clear_strobes();
        valid_in = 1'b1; chainId_in = 2'd0; vector_in = v; eof_in = 1'b0;
        thr_wr_en = 1'b1; thr_wr_set = 2'd0; thr_wr_bin = 2'd1; thr_wr_data = 32'd4;
        expect_beat(0, v, 1'b0);
        thr_m[0][1] = 4;
        beat(0, v, 1'b0, 1'b1);
        thr(0, 1, 10);
        idle(3);

        // Accumulation over a three-beat frame, then a one-beat frame.
        cfg(1, 0, 2); cfg(1, 2, 1);
        beat(1, v, 1'b0, 1'b1);
        beat(1, v, 1'b0, 1'b1);
        beat(1, v, 1'b1, 1'b1);
        idle(1);
        beat(1, v, 1'b1, 1'b1);
        idle(3);

        // Saturation: narrow instance clamps at 3, wide instance reaches 12.
        cfg(2, 0, 2); cfg(2, 2, 1);
        beat(2, vec4(5, 5, 5, 5), 1'b0, 1'b1);
        beat(2, vec4(5, 5, 5, 5), 1'b0, 1'b1);
        beat(2, vec4(5, 5, 5, 5), 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        checks++; assert (sat_valid_out === 1'b1) else begin errors++; $error("FAIL sat_valid got %0b exp 1", sat_valid_out); end
        checks++; assert (sat_vector_out === vec4(3, 0, 0, 0)) else begin errors++; $error("FAIL sat_vector got %h exp %h", sat_vector_out, vec4(3, 0, 0, 0)); end
        checks++; assert (sat_eof_out === 1'b1) else begin errors++; $error("FAIL sat_eof got %0b exp 1", sat_eof_out); end
        idle(3);

        // Clear coinciding with the S2 accumulate keeps that beat.
        beat(1, v, 1'b0, 1'b1);
        @(negedge clk);
        clear_strobes();
        valid_in = 1'b0; acc_clear = 1'b1;
        beat(1, v, 1'b1, 1'b1);
        idle(3);

        // Clear after the beat has landed discards it.
        beat(1, v, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        clear_strobes();
        acc_clear = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) acc_m[c][k] = 0;
        beat(1, v, 1'b1, 1'b1);
        idle(3);

        // Interleaved chains with tracing low for two cycles.
        cfg(0, 0, 1); cfg(0, 2, 1); cfg(0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) beat(0, v0, 1'b0, !(k == 3 || k == 4));
            else            beat(1, v, (k == 7), !(k == 3 || k == 4));
        end
        idle(4);

        // Reset mid-frame discards the partial accumulation.
        beat(1, v, 1'b0, 1'b1);
        beat(1, v, 1'b0, 1'b1);
        do_reset();
        thr(0, 0, 0); thr(0, 1, 10); thr(0, 2, 20); thr(0, 3, 30);
        cfg(1, 0, 2); cfg(1, 2, 1);
        beat(1, v, 1'b1, 1'b1);
        idle(3);

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++; $error("FAIL drain pending %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
